// File: rtl/spart_rx_if.sv
// spart_rx_if: receive-side signal bundle between the baud/bus logic and the
// SPART receiver. The perr signal only exists when SPART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface spart_rx_if;
    logic       enb;
    logic       rxd;
    logic       rd_clr;
    logic [7:0] rx_data;
    logic       rda;
    logic       ferr;
    logic       ovr;
`ifdef SPART_RX_PARITY_EN
    logic       perr;
`endif

    // Bus/baud side: drives the tick, the line and the read strobe.
    modport master (
        output enb, rxd, rd_clr,
        input  rx_data, rda, ferr, ovr
`ifdef SPART_RX_PARITY_EN
        , input perr
`endif
    );

    // Receiver side.
    modport slave (
        input  enb, rxd, rd_clr,
        output rx_data, rda, ferr, ovr
`ifdef SPART_RX_PARITY_EN
        , output perr
`endif
    );
endinterface

// File: rtl/spart_rx.sv
// spart_rx: RS232 receiver with 16x oversampling. Detects the start bit on a
// synchronized line, re-checks it at mid bit, then samples every 16 ticks.
// Frame is 8N1 by default; defining SPART_RX_PARITY_EN adds one even-parity
// bit between data and stop and the perr flag.
`timescale 1ns/1ps
module spart_rx (
    input logic       clk,
    input logic       rst,
    spart_rx_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic       rx_meta;
    logic       rxs;
    logic [2:0] state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       frame_done;
    logic [7:0] rx_data;
    logic       rda;
    logic       ferr;
    logic       ovr;
`ifdef SPART_RX_PARITY_EN
    logic       par_bit;
    logic       perr;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rxd;
            rxs     <= rx_meta;
        end
    end

    // Stop bit is sampled on the 16th tick of STOP; outputs load on that same edge.
    assign frame_done = bus.enb && (state == STOP) && (tick_cnt == 4'd15);

    // Frame state machine; everything advances only on the oversampling tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
`ifdef SPART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (bus.enb) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        tick_cnt <= 4'd0;
                        state    <= START;
                    end
                end
                START: begin
                    // Eighth tick lands mid start bit; a high here was a glitch.
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    // Counter wraps 15->0 naturally, so each bit is exactly 16 ticks.
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        par_bit <= rxs;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Receive buffer and status flags; a completing byte beats a coincident read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= 8'h00;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            perr    <= 1'b0;
`endif
        end else if (frame_done) begin
            rx_data <= shreg;
            rda     <= 1'b1;
            ferr    <= ~rxs;
            // Overrun only when the old byte was unread and not being read now.
            if (rda && !bus.rd_clr) begin
                ovr <= 1'b1;
            end
`ifdef SPART_RX_PARITY_EN
            perr    <= (^shreg) ^ par_bit;
`endif
        end else if (bus.rd_clr) begin
            rda <= 1'b0;
            ovr <= 1'b0;
        end
    end

    assign bus.rx_data = rx_data;
    assign bus.rda     = rda;
    assign bus.ferr    = ferr;
    assign bus.ovr     = ovr;
`ifdef SPART_RX_PARITY_EN
    assign bus.perr    = perr;
`endif

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: 100 MHz system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port enb, input, 1 bit: 16x-baud sample tick from the baud generator, one clk wide.
REQ-004 SHALL have port rxd, input, 1 bit: RS232 serial receive line, asynchronous, idle high.
REQ-005 SHALL have port rd_clr, input, 1 bit: one-clk strobe from the bus interface when the CPU reads the receive buffer.
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 SHALL have port rda, output, 1 bit: receive data available.
REQ-008 SHALL have port ferr, output, 1 bit: framing error on last byte.
REQ-009 SHALL have port ovr, output, 1 bit: overrun, sticky.
REQ-010 SHALL have port perr, output, 1 bit: parity error; exists only with SPART_RX_PARITY_EN.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer; only the synchronized value rxs is used.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP; the 4-bit tick counter and 3-bit bit counter advance only on enb.
REQ-013 IDLE: on an enb tick with rxs=0, SHALL clear the tick counter and go to START.
REQ-014 START: on the 8th enb tick (mid start bit), SHALL go to DATA if rxs=0 with counters cleared; otherwise SHALL treat the low as a glitch and return to IDLE.
REQ-015 DATA: every 16th enb tick SHALL shift rxs into the MSB of an 8-bit shift register (LSB first); after bit 7 SHALL go to PARITY (macro) or STOP.
REQ-016 STOP: on the 16th enb tick SHALL sample the stop bit, load rx_data from the shift register, set rda, set ferr to the inverse of the stop sample, and return to IDLE in the same cycle.
REQ-017 rda, rx_data, ferr (and perr) SHALL update one clk after the enb tick that samples the stop bit.
REQ-018 A zero stop bit SHALL still deliver the byte with rda=1 and ferr=1.
REQ-019 rd_clr SHALL clear rda and ovr on the next edge; rx_data and ferr SHALL hold.
REQ-020 If a byte completes while rda=1, SHALL overwrite rx_data and set ovr.
REQ-021 If rd_clr and byte completion coincide, set SHALL win: rda=1, new data, ovr unchanged.
REQ-022 rd_clr with rda=0 SHALL have no effect other than clearing ovr.
REQ-023 The tick counter SHALL wrap 15->0 without a skipped or extra sample.

Reset
REQ-024 While rst=1: state IDLE, both counters 0, shift register 0x00, synchronizer flops 1.
REQ-025 While rst=1: rx_data=0x00, rda=0, ferr=0, ovr=0, perr=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-027 With SPART_RX_PARITY_EN defined: PARITY SHALL sample one even-parity bit after 16 ticks and set perr when the XOR of the 8 data bits and the parity bit is 1; perr loads with rx_data.
REQ-028 Without SPART_RX_PARITY_EN: no PARITY state and no perr port; the frame is 8N1.

Verification
REQ-029 enb every 40 clk (6400 ns/bit); send 8N1 frame data bits 0,0,1,0,0,0,1,0 (LSB first), stop 1 -> rx_data=0x44, rda=1, ferr=0 one clk after the stop sample.
REQ-030 rxd low for 3 enb ticks, then high -> state back to IDLE, rda stays 0, the next valid frame 0xA5 is received correctly.
REQ-031 Frame 0x3C with stop bit 0 -> rx_data=0x3C, rda=1, ferr=1; the next frame 0x3D with a good stop -> ferr=0.
REQ-032 Frames 0x11 then 0x22 with no rd_clr -> rx_data=0x22, ovr=1; rd_clr pulse -> rda=0, ovr=0, rx_data=0x22.
REQ-033 rd_clr on the same clk as completion of 0x55 -> rda=1, rx_data=0x55.
REQ-034 Reset pulsed after data bit 3 of a frame -> all outputs zero, then the following frame 0x7E is received intact; with the macro defined, 0x07 with parity 0 -> perr=1.
